unified_mem_arbiter: RTL and testbench

Shares one single-ported, fixed-latency memory between the pipeline's instruction-fetch port and its data-memory port. The block sits between the fetch and MEM stages and the memory array. It serialises their word requests with a req/ack handshake and alternates grants on ties, so neither stage can starve the other. A halt input stops new fetches once the trap instruction is decoded, while still draining data accesses.

---
 rtl/unified_mem_arbiter_if.sv | 41 ++++
 rtl/unified_mem_arbiter.sv | 99 +++++++++
 tb/tb_unified_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch port, data port, halt/busy and memory-side signals
// shared between the unified memory arbiter and its surroundings.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  logic              halt;
  logic              busy;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, halt, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester and memory side
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, halt, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and
// data memory, alternating grants on ties; halt blocks only new fetch grants.
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic                  clk,
  input logic                  rst,
  unified_mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

  stateT             state;
  stateT             nextState;
  logic [CNT_W-1:0]  waitCnt;
  logic              lastDm;
  logic              grantDm;
  logic              ifEligible;
  logic              grantValid;
  logic              pickDm;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] ifRdata;
  logic [DATA_W-1:0] dmRdata;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Arbitration and next state; on a tie the port not granted last wins
  always_comb begin
    ifEligible = bus.if_req && !bus.halt;
    grantValid = bus.dm_req || ifEligible;
    pickDm     = bus.dm_req && (!ifEligible || !lastDm);
    nextState  = state;
    case (state)
      IDLE:    if (grantValid) nextState = ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT:    if (waitCnt == '0) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Grant latch, latency counter and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastDm   <= 1'b0;
      grantDm  <= 1'b0;
      waitCnt  <= '0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      ifRdata  <= '0;
      dmRdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantValid) begin
            grantDm <= pickDm;
            lastDm  <= pickDm;
            memAddr <= pickDm ? bus.dm_addr : bus.if_addr;
            memWe   <= pickDm && bus.dm_we;
            if (pickDm) memWdata <= bus.dm_wdata;
          end
        end
        ISSUE: waitCnt <= CNT_W'(MEM_LAT - 1);
        WAIT: begin
          if (waitCnt != '0) begin
            waitCnt <= waitCnt - CNT_W'(1);
          end else if (!memWe) begin
            if (grantDm) dmRdata <= bus.mem_rdata;
            else         ifRdata <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so reset removes them immediately
  assign bus.busy      = (state != IDLE);
  assign bus.mem_en    = (state == ISSUE);
  assign bus.if_ack    = (state == RESP) && !grantDm;
  assign bus.dm_ack    = (state == RESP) && grantDm;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.if_rdata  = ifRdata;
  assign bus.dm_rdata  = dmRdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: stimulus pushes expected memory
// strobes and acks into queues, a negedge monitor pops and compares them.
module tb_unified_mem_arbiter;

  localparam int MEM_LAT = 2;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } memExpT;

  typedef struct {
    bit          isDm;
    logic [31:0] rdata;
  } ackExpT;

  logic clk;
  logic rst;
  int   cycle;
  int   vectors;
  int   miscompares;
  int   lastMemEn;
  int   c;
  int   r;
  int   t;
  int   memEnSeen;
  int   busySeen;

  memExpT memQ[$];
  ackExpT ackQ[$];
  memExpT monM;
  ackExpT monA;

  logic [31:0] mem [0:4095];
  logic [31:0] d1;
  logic        v1;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Memory model: read data appears exactly MEM_LAT cycles after mem_en, poison otherwise
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[13:2]] <= bus.mem_wdata;
    d1            <= mem[bus.mem_addr[13:2]];
    v1            <= bus.mem_en && !bus.mem_we;
    bus.mem_rdata <= v1 ? d1 : 32'hBAD0_BAD0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at cycle %0d",
               name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input bit isDm, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRdata,
                               input int memCyc, input bit ackExpected);
    memExpT m;
    ackExpT a;
    m.we = we; m.addr = addr; m.wdata = wdata; m.cyc = memCyc;
    memQ.push_back(m);
    if (ackExpected) begin
      a.isDm = isDm; a.rdata = expRdata;
      ackQ.push_back(a);
    end
    if (isDm) begin
      bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
  endtask

  task automatic waitAck(input bit isDm, output int ackCyc);
    bit done;
    done   = 1'b0;
    ackCyc = -1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (isDm ? bus.dm_ack : bus.if_ack) begin
        done   = 1'b1;
        ackCyc = cycle;
        if (isDm) bus.dm_req = 1'b0;
        else      bus.if_req = 1'b0;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ackTimeout: got no %s ack, want one within 20 cycles",
               isDm ? "dm" : "if");
      if (isDm) bus.dm_req = 1'b0;
      else      bus.if_req = 1'b0;
    end
  endtask

  // Monitor: every mem_en and every ack must match the next queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_en) begin
        if (memQ.size() == 0) begin
          vectors++; miscompares++;
          $display("[TB] FAIL unexpectedMemEn: got mem_en=1 addr 0x%08h, want none", bus.mem_addr);
        end else begin
          monM = memQ.pop_front();
          checkOutput("memAddr", bus.mem_addr, monM.addr);
          checkOutput("memWe", {31'b0, bus.mem_we}, {31'b0, monM.we});
          if (monM.we) checkOutput("memWdata", bus.mem_wdata, monM.wdata);
          checkOutput("memEnCycle", cycle, monM.cyc);
        end
        lastMemEn = cycle;
      end
      if (bus.if_ack || bus.dm_ack) begin
        if (bus.if_ack && bus.dm_ack) begin
          vectors++; miscompares++;
          $display("[TB] FAIL dualAck: got if_ack=1 dm_ack=1, want one at most");
        end
        if (ackQ.size() == 0) begin
          vectors++; miscompares++;
          $display("[TB] FAIL unexpectedAck: got if_ack=%0b dm_ack=%0b, want none",
                   bus.if_ack, bus.dm_ack);
        end else begin
          monA = ackQ.pop_front();
          checkOutput("ackPort", {31'b0, bus.dm_ack}, {31'b0, monA.isDm});
          if (monA.isDm) checkOutput("dmRdata", bus.dm_rdata, monA.rdata);
          else           checkOutput("ifRdata", bus.if_rdata, monA.rdata);
          checkOutput("ackLatency", cycle - lastMemEn, MEM_LAT + 1);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got no end of test, want completion before 20000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors = 0; miscompares = 0; lastMemEn = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[16]   = 32'h2001_0004;
    mem[17]   = 32'h0050_0093;
    mem[18]   = 32'h00A0_0113;
    mem[19]   = 32'h0000_0073;
    mem[2048] = 32'h1234_5678;
    mem[2049] = 32'h0000_0000;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.halt = 1'b0;
    rst = 1'b1;

    #1;
    checkOutput("rstBusy",     {31'b0, bus.busy},   32'h0);
    checkOutput("rstMemEn",    {31'b0, bus.mem_en}, 32'h0);
    checkOutput("rstMemWe",    {31'b0, bus.mem_we}, 32'h0);
    checkOutput("rstIfAck",    {31'b0, bus.if_ack}, 32'h0);
    checkOutput("rstDmAck",    {31'b0, bus.dm_ack}, 32'h0);
    checkOutput("rstMemAddr",  bus.mem_addr,  32'h0);
    checkOutput("rstMemWdata", bus.mem_wdata, 32'h0);
    checkOutput("rstIfRdata",  bus.if_rdata,  32'h0);
    checkOutput("rstDmRdata",  bus.dm_rdata,  32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single fetch of 0x40
    @(negedge clk); c = cycle;
    applyStimulus(1'b0, 1'b0, 32'h40, 32'h0, 32'h2001_0004, c + 1, 1'b1);
    waitAck(1'b0, t);
    checkOutput("fetchAckCycle", t, c + 4);
    repeat (3) @(negedge clk);
    checkOutput("ifRdataHeld", bus.if_rdata, 32'h2001_0004);

    // Ties alternate: DM, IF, DM, IF
    @(negedge clk); c = cycle;
    applyStimulus(1'b1, 1'b0, 32'h2000, 32'h0, 32'h1234_5678, c + 1, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h44, 32'h0, 32'h0050_0093, c + 6, 1'b1);
    waitAck(1'b1, t);
    checkOutput("tieDmAck1", t, c + 4);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h2000, 32'h0, 32'h1234_5678, c + 11, 1'b1);
    waitAck(1'b0, t);
    checkOutput("tieIfAck1", t, c + 9);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h44, 32'h0, 32'h0050_0093, c + 16, 1'b1);
    waitAck(1'b1, t);
    checkOutput("tieDmAck2", t, c + 14);
    waitAck(1'b0, t);
    checkOutput("tieIfAck2", t, c + 19);

    // DM write leaves dm_rdata at the last read value
    @(negedge clk); c = cycle;
    applyStimulus(1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF, 32'h1234_5678, c + 1, 1'b1);
    waitAck(1'b1, t);
    checkOutput("writeAckCycle", t, c + 4);
    bus.dm_we = 1'b0;

    // halt rises together with if_req: no fetch grant, DM still served
    @(negedge clk);
    bus.halt = 1'b1; bus.if_req = 1'b1; bus.if_addr = 32'h48;
    memEnSeen = 0; busySeen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.mem_en) memEnSeen++;
      if (bus.busy)   busySeen++;
    end
    checkOutput("haltMemEnCount", memEnSeen, 32'h0);
    checkOutput("haltBusyCount",  busySeen,  32'h0);
    c = cycle;
    applyStimulus(1'b1, 1'b0, 32'h2004, 32'h0, 32'hDEAD_BEEF, c + 1, 1'b1);
    waitAck(1'b1, t);
    checkOutput("haltDmAckCycle", t, c + 4);
    @(negedge clk); c = cycle;
    bus.halt = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h48, 32'h0, 32'h00A0_0113, c + 1, 1'b1);
    waitAck(1'b0, t);
    checkOutput("unhaltIfAckCycle", t, c + 4);

    // Reset while a fetch waits in WAIT abandons it; the held request re-arbitrates
    @(negedge clk); c = cycle;
    applyStimulus(1'b0, 1'b0, 32'h4C, 32'h0, 32'h0, c + 1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midRstBusy",    {31'b0, bus.busy},   32'h0);
    checkOutput("midRstMemEn",   {31'b0, bus.mem_en}, 32'h0);
    checkOutput("midRstIfAck",   {31'b0, bus.if_ack}, 32'h0);
    checkOutput("midRstIfRdata", bus.if_rdata, 32'h0);
    checkOutput("midRstDmRdata", bus.dm_rdata, 32'h0);
    checkOutput("midRstMemAddr", bus.mem_addr, 32'h0);
    @(negedge clk); r = cycle;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h4C, 32'h0, 32'h0000_0073, r + 1, 1'b1);
    waitAck(1'b0, t);
    checkOutput("postRstAckCycle", t, r + 4);

    repeat (3) @(negedge clk);
    checkOutput("memQueueDrained", memQ.size(), 32'h0);
    checkOutput("ackQueueDrained", ackQ.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
